// File: rtl/sd_clock_ctrl.sv
// SD clock controller: mirrors the SD clock divider, sequences run/stop/init bursts and glitch-free divider changes.
// Latency: strobes are combinational from state; DIVIDER/DIV_ACK/INIT_DONE update on the CLK edge after the deciding cycle.
// Backpressure: none; requests are single-cycle pulses, divider writes are held pending until a safe LOAD slot.
module sd_clock_ctrl #(
    parameter logic [7:0] DEFAULT_DIV = 8'd124,
    parameter int         INIT_CYCLES = 80
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DIV_IN,
    input  logic       DIV_WR,
    input  logic       CLK_EN,
    input  logic       INIT_REQ,
    output logic [7:0] DIVIDER,
    output logic       DIV_RST,
    output logic       RISE_STB,
    output logic       FALL_STB,
    output logic       DIV_ACK,
    output logic       INIT_DONE,
    output logic       BUSY
);

    localparam int RW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_INIT,
        ST_STOP_WAIT,
        ST_LOAD
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            phase_q, phase_d;
    logic [7:0]      divider_q, divider_d;
    logic            pend_q, pend_d;
    logic [7:0]      pend_val_q, pend_val_d;
    logic            ack_q, ack_d;
    logic            init_done_q, init_done_d;
    logic [RW-1:0]   rise_cnt_q, rise_cnt_d;

    logic div_rst;
    logic term_cnt;
    logic rise_stb;
    logic fall_stb;

    // Divider is held in reset whenever the SD clock must sit low and idle.
    assign div_rst  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign term_cnt = (cnt_q == divider_q);
    assign rise_stb = !div_rst && term_cnt && !phase_q;
    assign fall_stb = !div_rst && term_cnt && phase_q;

    assign DIVIDER   = divider_q;
    assign DIV_RST   = div_rst;
    assign RISE_STB  = rise_stb;
    assign FALL_STB  = fall_stb;
    assign DIV_ACK   = ack_q;
    assign INIT_DONE = init_done_q;
    assign BUSY      = (state_q != ST_IDLE) && (state_q != ST_RUN);

    // Mirror of the external divider counter and SD clock phase.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (div_rst) begin
            cnt_d   = 8'd0;
            phase_d = 1'b0;
        end else if (term_cnt) begin
            cnt_d   = 8'd0;
            phase_d = !phase_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Control FSM: next state, divider load, pending write capture and init bookkeeping.
    always_comb begin
        state_d     = state_q;
        divider_d   = divider_q;
        pend_d      = pend_q;
        pend_val_d  = pend_val_q;
        ack_d       = 1'b0;
        init_done_d = init_done_q;
        rise_cnt_d  = rise_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // A pending write that survived a LOAD collision is honoured here too.
                if (DIV_WR || pend_q) begin
                    state_d = ST_LOAD;
                end else if (INIT_REQ) begin
                    state_d     = ST_INIT;
                    init_done_d = 1'b0;
                    rise_cnt_d  = '0;
                end else if (CLK_EN) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (DIV_WR || pend_q) begin
                    state_d = ST_STOP_WAIT;
                end else if (INIT_REQ) begin
                    // Counter keeps running, so the burst joins the live clock seamlessly.
                    state_d     = ST_INIT;
                    init_done_d = 1'b0;
                    rise_cnt_d  = '0;
                end else if (!CLK_EN) begin
                    state_d = ST_STOP_WAIT;
                end
            end
            ST_INIT: begin
                if (rise_stb) begin
                    if (rise_cnt_q == RW'(INIT_CYCLES - 1)) begin
                        state_d     = ST_STOP_WAIT;
                        init_done_d = 1'b1;
                    end else begin
                        rise_cnt_d = rise_cnt_q + RW'(1);
                    end
                end
            end
            ST_STOP_WAIT: begin
                // Leave only on a falling edge so the SD clock always parks low.
                if (fall_stb) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (pend_q) begin
                    divider_d = pend_val_q;
                    ack_d     = 1'b1;
                    pend_d    = 1'b0;
                end
                state_d = CLK_EN ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Last write wins; a write coinciding with LOAD stays pending for the next slot.
        if (DIV_WR) begin
            pend_d     = 1'b1;
            pend_val_d = DIV_IN;
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            phase_q     <= 1'b0;
            divider_q   <= DEFAULT_DIV;
            pend_q      <= 1'b0;
            pend_val_q  <= 8'd0;
            ack_q       <= 1'b0;
            init_done_q <= 1'b0;
            rise_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            divider_q   <= divider_d;
            pend_q      <= pend_d;
            pend_val_q  <= pend_val_d;
            ack_q       <= ack_d;
            init_done_q <= init_done_d;
            rise_cnt_q  <= rise_cnt_d;
        end
    end

endmodule

// File: doc/sd_clock_ctrl.md
SD_CLOCK_CTRL -- requirements
Module: sd_clock_ctrl

Interface
REQ-001 Parameter DEFAULT_DIV, default 8'd124: divider value loaded at reset (400 kHz SD clock from a 100 MHz CLK).
REQ-002 Parameter INIT_CYCLES, default 80: number of SD clock rising edges issued by an init sequence.
REQ-003 CLK  in  1  system clock; all logic on the rising edge.
REQ-004 RST  in  1  asynchronous, active-low reset.
REQ-005 DIV_IN  in  8  new divider value, sampled when DIV_WR=1.
REQ-006 DIV_WR  in  1  one-cycle divider-change request.
REQ-007 CLK_EN  in  1  level; 1 = SD clock shall run.
REQ-008 INIT_REQ  in  1  one-cycle request for an init burst.
REQ-009 DIVIDER  out  8  divider value driven to the SD clock divider.
REQ-010 DIV_RST  out  1  active-high hold/reset for the divider (counter 0, SD clock low).
REQ-011 RISE_STB  out  1  high in the CLK cycle whose closing edge drives the SD clock high.
REQ-012 FALL_STB  out  1  high in the CLK cycle whose closing edge drives the SD clock low.
REQ-013 DIV_ACK  out  1  one-cycle pulse when DIVIDER takes a newly requested value.
REQ-014 INIT_DONE  out  1  sticky; init burst completed.
REQ-015 BUSY  out  1  high when the state is not IDLE and not RUN.

Function
REQ-016 Mirror counter cnt[7:0] and phase: DIV_RST=1 -> cnt=0, phase=0; else cnt==DIVIDER -> cnt=0, phase toggles; else cnt+1.
REQ-017 RISE_STB = !DIV_RST & cnt==DIVIDER & !phase; FALL_STB = !DIV_RST & cnt==DIVIDER & phase (combinational); SD clock period = 2*(DIVIDER+1) CLK cycles.
REQ-018 States: IDLE, RUN, INIT, STOP_WAIT, LOAD; DIV_RST=1 in IDLE and LOAD, 0 in RUN, INIT and STOP_WAIT.
REQ-019 IDLE priority: DIV_WR -> LOAD; else INIT_REQ -> INIT (clears INIT_DONE); else CLK_EN=1 -> RUN.
REQ-020 RUN priority: DIV_WR -> STOP_WAIT; else INIT_REQ -> INIT (clears INIT_DONE, clock not interrupted); else CLK_EN=0 -> STOP_WAIT.
REQ-021 DIV_WR in any state latches DIV_IN into a pending register and sets a pending flag; a later write before LOAD overwrites it (last write wins, single DIV_ACK).
REQ-022 INIT: counts RISE_STB; on the cycle of the INIT_CYCLES-th RISE_STB -> STOP_WAIT and INIT_DONE is set on that edge.
REQ-023 STOP_WAIT: remains until FALL_STB=1, then -> LOAD; SD clock is therefore always stopped low, no runt pulse.
REQ-024 LOAD (exactly one cycle): if pending, DIVIDER <= pending, DIV_ACK=1 on the following cycle, pending cleared; next state RUN if CLK_EN=1, else IDLE.
REQ-025 INIT_REQ in INIT, STOP_WAIT or LOAD is ignored; DIV_WR in INIT is held pending until the burst completes.
REQ-026 DIVIDER=0 is legal (SD clock = CLK/2, RISE_STB/FALL_STB alternate every cycle).
REQ-027 DIVIDER changes only in LOAD, i.e. only while DIV_RST=1.

Reset
REQ-028 RST=0 forces immediately: state IDLE, DIVIDER=DEFAULT_DIV, DIV_RST=1, cnt=0, phase=0, pending cleared, DIV_ACK=0, INIT_DONE=0, BUSY=0; RISE_STB/FALL_STB=0.
REQ-029 Reset asserted mid-INIT or mid-STOP_WAIT aborts the operation; no DIV_ACK, no INIT_DONE.

Verification
REQ-030 Reset release, CLK_EN=1: DIV_RST falls one cycle later; first RISE_STB 125 cycles after that, FALL_STB every 250 cycles thereafter.
REQ-031 In IDLE, DIV_WR with DIV_IN=2: one LOAD cycle, DIVIDER=2, DIV_ACK one pulse; then CLK_EN=1 gives RISE_STB every 6 cycles.
REQ-032 RUN with DIVIDER=2, DIV_WR DIV_IN=0 mid high phase: STOP_WAIT until FALL_STB, LOAD, DIVIDER=0, back to RUN; strobes then alternate every cycle.
REQ-033 DIVIDER=2, INIT_REQ in IDLE with CLK_EN=0: exactly 80 RISE_STB, INIT_DONE set, then ends in IDLE with DIV_RST=1; BUSY high throughout.
REQ-034 Two DIV_WR (values 5 then 7) during INIT: after burst, DIVIDER=7, exactly one DIV_ACK.
REQ-035 RST=0 during INIT at rise 40: all outputs at reset values same cycle; INIT_DONE stays 0.
